// File: rtl/vga_timing_gen_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_pkg
// Shared VGA raster constants for the timing generator and the sprite and
// background controllers. These controllers position themselves against the
// same values, so they cannot drift from the sync timing.
//   - 640x480 @ 60 Hz defaults for the horizontal (pixels) and vertical (lines)
//     sync, back porch, active and front porch widths, plus the derived
//     totals and active-window start positions.
//   - coord_t: the 10-bit raster coordinate type used by every compare.
//   - in_window(): inclusive range test used by the active-window decode.
// -----------------------------------------------------------------------------
package vga_timing_gen_pkg;

    localparam int COORD_W     = 10;
    localparam int COORD_LIMIT = 1 << COORD_W;

    typedef logic [COORD_W-1:0] coord_t;

    localparam int CLK_DIV_DEF  = 4;

    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;

    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;

    localparam int H_TOTAL     = H_SYNC_DEF + H_BP_DEF + H_ACTIVE_DEF + H_FP_DEF;  // 800
    localparam int V_TOTAL     = V_SYNC_DEF + V_BP_DEF + V_ACTIVE_DEF + V_FP_DEF;  // 525
    localparam int H_ACT_START = H_SYNC_DEF + H_BP_DEF;                           // 144
    localparam int V_ACT_START = V_SYNC_DEF + V_BP_DEF;                           // 35

    // Inclusive window test on raster coordinates (unsigned, 10-bit).
    function automatic logic in_window(input coord_t pos, input coord_t lo, input coord_t hi);
        return (pos >= lo) && (pos <= hi);
    endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// -----------------------------------------------------------------------------
// pix_tick_gen
// Free-running divider that turns the board clock into a one-cycle pixel
// enable. The divider counts 0..CLK_DIV-1 and wraps. pix_en is registered from
// the terminal count. As a result, pix_en is high for exactly one of every
// CLK_DIV cycles, and the first pulse appears CLK_DIV cycles after reset
// deasserts.
// Parameters:
//   CLK_DIV  ClkPort cycles per pixel (>= 2)
// Ports:
//   ClkPort  in   1  board clock
//   rst      in   1  asynchronous, active-high reset
//   pix_en   out  1  one-cycle pixel-enable pulse
// -----------------------------------------------------------------------------
module pix_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic ClkPort,
    input  logic rst,
    output logic pix_en
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (CLK_DIV < 2) begin : g_clk_div_check
        $error("pix_tick_gen: CLK_DIV must be >= 2");
    end

    logic [DIV_W-1:0] div_q;

    // NOTE: sequential state is written with non-blocking assignments, so every
    // flop samples pre-edge values and the block has no evaluation order hazards.
    always_ff @(posedge ClkPort or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            pix_en <= 1'b0;
        end else begin
            pix_en <= (div_q == DIV_LAST);
            div_q  <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Upstream timing stage of the VGA pixel path. It runs hCount/vCount over the
// raster, with sync first, then back porch, active area and front porch.
// hCount and vCount advance once per pix_en tick, so each coordinate is held
// for CLK_DIV ClkPort cycles. This gives downstream ROMs clocked on ClkPort
// time to absorb one cycle of latency.
// hSync, vSync and bright are registered from the next-state counts, so they
// change on the same edge as the counters (zero skew).
// Optional feature: define VGA_FRAME_COUNT_EN to add the 16-bit frame_count
// output, which increments (mod 2^16) on every frame_start.
// Ports:
//   ClkPort      in   1   board clock (100 MHz)
//   rst          in   1   asynchronous, active-high reset
//   pix_en       out  1   one-cycle pixel-enable pulse
//   hCount       out  10  horizontal position, 0..H_TOTAL-1
//   vCount       out  10  vertical position, 0..V_TOTAL-1
//   hSync        out  1   active-low horizontal sync
//   vSync        out  1   active-low vertical sync
//   bright       out  1   high inside the active window
//   frame_start  out  1   one-cycle pulse after the raster wraps to (0,0)
//   frame_count  out  16  frame counter (VGA_FRAME_COUNT_EN only)
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int CLK_DIV  = CLK_DIV_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF
) (
    input  logic        ClkPort,
    input  logic        rst,
    output logic        pix_en,
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        hSync,
    output logic        vSync,
    output logic        bright,
    output logic        frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam coord_t H_LAST      = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST      = coord_t'(V_TOT - 1);
    localparam coord_t H_SYNC_END  = coord_t'(H_SYNC);
    localparam coord_t V_SYNC_END  = coord_t'(V_SYNC);
    localparam coord_t H_ACT_FIRST = coord_t'(H_SYNC + H_BP);
    localparam coord_t H_ACT_LAST  = coord_t'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam coord_t V_ACT_FIRST = coord_t'(V_SYNC + V_BP);
    localparam coord_t V_ACT_LAST  = coord_t'(V_SYNC + V_BP + V_ACTIVE - 1);

    // The counters and compares are 10 bits wide, so a larger raster cannot
    // be represented.
    if (H_TOT > COORD_LIMIT) begin : g_h_total_check
        $error("vga_timing_gen: H_TOTAL exceeds the 10-bit coordinate range");
    end
    if (V_TOT > COORD_LIMIT) begin : g_v_total_check
        $error("vga_timing_gen: V_TOTAL exceeds the 10-bit coordinate range");
    end

    pix_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick_gen (
        .ClkPort (ClkPort),
        .rst     (rst),
        .pix_en  (pix_en)
    );

    coord_t h_next;
    coord_t v_next;
    logic   frame_wrap;

    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        h_next     = hCount;
        v_next     = vCount;
        frame_wrap = 1'b0;
        if (pix_en) begin
            if (hCount == H_LAST) begin
                h_next = '0;
                if (vCount == V_LAST) begin
                    v_next     = '0;
                    frame_wrap = 1'b1;
                end else begin
                    v_next = vCount + 10'd1;
                end
            end else begin
                h_next = hCount + 10'd1;
            end
        end
    end

    // Decode from the next-state counts so that the sync and blanking flops
    // change on the same edge as hCount/vCount.
    always_ff @(posedge ClkPort or posedge rst) begin
        if (rst) begin
            hCount      <= '0;
            vCount      <= '0;
            hSync       <= 1'b0;
            vSync       <= 1'b0;
            bright      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hCount      <= h_next;
            vCount      <= v_next;
            hSync       <= !(h_next < H_SYNC_END);
            vSync       <= !(v_next < V_SYNC_END);
            bright      <= in_window(h_next, H_ACT_FIRST, H_ACT_LAST)
                        && in_window(v_next, V_ACT_FIRST, V_ACT_LAST);
            // frame_wrap only fires on a pix_en cycle, so this is a single-cycle pulse.
            frame_start <= frame_wrap;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    always_ff @(posedge ClkPort or posedge rst) begin
        if (rst) begin
            frame_count <= '0;
        end else if (frame_start) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Directed bench for vga_timing_gen. Horizontal timing uses the 640x480
// defaults. The vertical raster is shortened to 5 lines (sync 2, back porch 1,
// active 1, front porch 1) so that whole frames fit in a short run.
// Outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_timing_gen;

    localparam int CLK_DIV  = 4;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam int V_ACTIVE = 1;
    localparam int V_FP     = 1;
    localparam int H_TOTAL  = 800;   // 96+48+640+16
    localparam int V_TOTAL  = 5;     // 2+1+1+1
    localparam int FRAME_CYC = H_TOTAL * V_TOTAL * CLK_DIV;  // 16000

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        hSync;
    logic        vSync;
    logic        bright;
    logic        frame_start;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_count;
`endif

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV  (CLK_DIV),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP)
    ) dut (
        .ClkPort     (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .hCount      (hCount),
        .vCount      (vCount),
        .hSync       (hSync),
        .vSync       (vSync),
        .bright      (bright),
        .frame_start (frame_start)
`ifdef VGA_FRAME_COUNT_EN
        ,
        .frame_count (frame_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Monitor state, updated on every sampled cycle by step().
    int cyc, first_pix, last_pix;
    int bad_pix, bad_hold, bad_wrap, wraps, h_over, v_over, max_h, max_v;
    int hs_run, hs_runs, bad_hrun, bad_hedge;
    int vs_run, vs_runs, bad_vrun, bad_vedge;
    int br_run, br_rises, bad_brun, bad_bedge;
    int fs_cnt, bad_fs, fs_prev_cyc, fs_period;
    bit hs_valid, vs_valid, br_valid;
    logic [9:0] p_h, p_v;
    logic p_pix, p_hs, p_vs, p_br, p_fs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic reset_monitor();
        cyc = 0; first_pix = -1; last_pix = -1;
        hs_valid = 0; vs_valid = 0; br_valid = 0;
        hs_run = 0; vs_run = 0; br_run = 0;
        fs_prev_cyc = -1;
        p_h = hCount; p_v = vCount; p_pix = pix_en;
        p_hs = hSync; p_vs = vSync; p_br = bright; p_fs = frame_start;
    endtask

    task automatic step();
        @(posedge clk); #1;
        cyc++;
        if (pix_en) begin
            if (last_pix >= 0 && (cyc - last_pix) != CLK_DIV) bad_pix++;
            if (first_pix < 0) first_pix = cyc;
            last_pix = cyc;
        end
        if ((hCount != p_h || vCount != p_v) && !p_pix) bad_hold++;
        if (int'(hCount) >= H_TOTAL) h_over++;
        if (int'(vCount) >= V_TOTAL) v_over++;
        if (int'(hCount) > max_h) max_h = int'(hCount);
        if (int'(vCount) > max_v) max_v = int'(vCount);
        if (p_pix && p_h == 10'd799 && p_v == 10'd4) begin
            wraps++;
            if (hCount != 10'd0 || vCount != 10'd0) bad_wrap++;
        end
        // hSync: falls at hCount 0, rises at hCount 96, low for 96*4 samples.
        if (p_hs && !hSync) begin
            hs_valid = 1; hs_run = 0;
            if (hCount != 10'd0) bad_hedge++;
        end
        if (!hSync && hs_valid) hs_run++;
        if (!p_hs && hSync) begin
            if (hCount != 10'd96) bad_hedge++;
            if (hs_valid) begin hs_runs++; if (hs_run != 384) bad_hrun++; end
            hs_valid = 0;
        end
        // vSync: falls at (0,0), rises at (0,2), low for 2*800*4 samples.
        if (p_vs && !vSync) begin
            vs_valid = 1; vs_run = 0;
            if (hCount != 10'd0 || vCount != 10'd0) bad_vedge++;
        end
        if (!vSync && vs_valid) vs_run++;
        if (!p_vs && vSync) begin
            if (hCount != 10'd0 || vCount != 10'd2) bad_vedge++;
            if (vs_valid) begin vs_runs++; if (vs_run != 6400) bad_vrun++; end
            vs_valid = 0;
        end
        // bright: rises at (144,3), falls at (784,3), high for 640*4 samples.
        if (!p_br && bright) begin
            br_rises++; br_valid = 1; br_run = 0;
            if (hCount != 10'd144 || vCount != 10'd3) bad_bedge++;
        end
        if (bright && br_valid) br_run++;
        if (p_br && !bright) begin
            if (hCount != 10'd784 || vCount != 10'd3) bad_bedge++;
            if (br_valid && br_run != 2560) bad_brun++;
            br_valid = 0;
        end
        if (frame_start) begin
            fs_cnt++;
            if (p_fs || hCount != 10'd0 || vCount != 10'd0) bad_fs++;
            if (fs_prev_cyc >= 0) fs_period = cyc - fs_prev_cyc;
            fs_prev_cyc = cyc;
        end
        p_h = hCount; p_v = vCount; p_pix = pix_en;
        p_hs = hSync; p_vs = vSync; p_br = bright; p_fs = frame_start;
    endtask

    task automatic run_until_fs(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && fs_cnt < target; i++) step();
        check(tag, (fs_cnt >= target), 1'b1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_pix_en"}, pix_en, 1'b0);
        check({tag, "_hCount"}, hCount, 10'd0);
        check({tag, "_vCount"}, vCount, 10'd0);
        check({tag, "_hSync"}, hSync, 1'b0);
        check({tag, "_vSync"}, vSync, 1'b0);
        check({tag, "_bright"}, bright, 1'b0);
        check({tag, "_frame_start"}, frame_start, 1'b0);
    endtask

    task automatic restart_and_check(input string tag);
        int fs_before;
        fs_before = fs_cnt;
        rst = 1'b0;
        reset_monitor();
        for (int i = 0; i < 20 && first_pix < 0; i++) step();
        check({tag, "_first_pix_cycle"}, first_pix, 4);
        check({tag, "_hCount_at_first_pix"}, hCount, 10'd0);
        step();
        check({tag, "_hCount_after_pix"}, hCount, 10'd1);
        check({tag, "_pix_en_one_cycle"}, pix_en, 1'b0);
        check({tag, "_no_frame_start"}, fs_cnt, fs_before);
    endtask

    initial begin
        bad_pix = 0; bad_hold = 0; bad_wrap = 0; wraps = 0; h_over = 0; v_over = 0;
        max_h = 0; max_v = 0; hs_runs = 0; bad_hrun = 0; bad_hedge = 0;
        vs_runs = 0; bad_vrun = 0; bad_vedge = 0; br_rises = 0; bad_brun = 0;
        bad_bedge = 0; fs_cnt = 0; bad_fs = 0; fs_period = 0;

        // 1. Reset for 10 cycles, then release between edges.
        rst = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        check_outputs_zero("reset");
        restart_and_check("start");

        // 2./4. First frame: line timing, active window and wrap.
        run_until_fs(1, FRAME_CYC + 100, "frame1_timeout");
        check("hsync_runs_seen", (hs_runs >= 4), 1'b1);
        check("hsync_low_384", bad_hrun, 0);
        check("hsync_edges", bad_hedge, 0);
        check("bright_one_line", br_rises, 1);
        check("bright_edges", bad_bedge, 0);
        check("bright_width_2560", bad_brun, 0);
        check("wrap_seen", wraps, 1);
        check("wrap_to_origin", bad_wrap, 0);

        // 3. Second frame: vSync width and frame period.
        run_until_fs(2, FRAME_CYC + 100, "frame2_timeout");
        check("vsync_runs", vs_runs, 1);
        check("vsync_low_6400", bad_vrun, 0);
        check("vsync_edges", bad_vedge, 0);
        check("frame_period", fs_period, FRAME_CYC);

`ifdef VGA_FRAME_COUNT_EN
        // 6. Frame counter: counts frame_start pulses and wraps mod 2^16.
        check("frame_count_1", frame_count, 16'd1);
        run_until_fs(3, FRAME_CYC + 100, "frame3_timeout");
        step();
        check("frame_count_3", frame_count, 16'd3);
        force dut.frame_count = 16'hFFFF;
        step();
        release dut.frame_count;
        run_until_fs(4, FRAME_CYC + 100, "frame4_timeout");
        step();
        check("frame_count_wrap", frame_count, 16'd0);
`endif

        // 5. Asynchronous reset mid-frame at (400,3), between clock edges.
        for (int i = 0; i < FRAME_CYC + 100 && !(hCount == 10'd400 && vCount == 10'd3); i++) step();
        check("reach_400_3", (hCount == 10'd400 && vCount == 10'd3), 1'b1);
        #2 rst = 1'b1;
        #1;
        check_outputs_zero("async_reset");
        repeat (3) begin @(posedge clk); #1; end
        restart_and_check("restart");
        repeat (20) step();

        // Whole-run invariants.
        check("pix_en_spacing", bad_pix, 0);
        check("counts_hold_between_ticks", bad_hold, 0);
        check("no_hcount_800", h_over, 0);
        check("no_vcount_overflow", v_over, 0);
        check("max_hcount_799", max_h, 799);
        check("max_vcount_4", max_v, 4);
        check("frame_start_single_at_origin", bad_fs, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
